// File: rtl/lapido_defs_pkg.sv
// Shared pipeline definitions for the lapido core: instruction/PC widths and the
// canonical no-op used wherever a stage has nothing valid to present.
package lapido_defs;

  localparam int INSTRUCTION_WIDTH = 32;
  localparam int PC_WIDTH          = 32;

  // addi x0, x0, 0
  localparam logic [INSTRUCTION_WIDTH-1:0] NOP_INSTRUCTION = 32'h0000_0013;

endpackage : lapido_defs

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: a small circular buffer between IF and ID
// with registered-only ready/valid, one-cycle push-to-head latency and flush.
module if_id_queue
  import lapido_defs::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         fetch_valid,
  input  logic [INSTRUCTION_WIDTH-1:0] fetch_instruction,
  input  logic [PC_WIDTH-1:0]          fetch_pc,
  output logic                         fetch_ready,
  input  logic                         flush,
  output logic                         dec_valid,
  output logic [INSTRUCTION_WIDTH-1:0] dec_instruction,
  output logic [PC_WIDTH-1:0]          dec_pc,
  input  logic                         dec_ready,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high and flush is low. fetch_ready and dec_valid depend only on registered
  // occupancy, so neither side sees a combinational path from the other.

  logic [INSTRUCTION_WIDTH-1:0] instr_mem [DEPTH];
  logic [PC_WIDTH-1:0]          pc_mem    [DEPTH];
  logic [PTR_W-1:0]             wr_ptr;
  logic [PTR_W-1:0]             rd_ptr;
  logic                         push;
  logic                         pop;

  assign fetch_ready = (count < FULL_COUNT);
  assign dec_valid   = (count != '0);

  assign push = fetch_valid & fetch_ready & ~flush;
  assign pop  = dec_valid & dec_ready & ~flush;

  // Head is read straight from storage; it cannot change while not popped.
  assign dec_instruction = dec_valid ? instr_mem[rd_ptr] : NOP_INSTRUCTION;
  assign dec_pc          = dec_valid ? pc_mem[rd_ptr]    : '0;

  // Storage is never reset; stale contents are masked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= fetch_instruction;
      pc_mem[wr_ptr]    <= fetch_pc;
    end
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule : if_id_queue

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue with DEPTH=4: reset, single push, fill, wrap,
// flush, stall and asynchronous reset scenarios.
module tb_if_id_queue;
  import lapido_defs::*;

  localparam int DEPTH = 4;

  logic                         clk;
  logic                         rst_n;
  logic                         fetch_valid;
  logic [INSTRUCTION_WIDTH-1:0] fetch_instruction;
  logic [PC_WIDTH-1:0]          fetch_pc;
  logic                         fetch_ready;
  logic                         flush;
  logic                         dec_valid;
  logic [INSTRUCTION_WIDTH-1:0] dec_instruction;
  logic [PC_WIDTH-1:0]          dec_pc;
  logic                         dec_ready;
  logic [2:0]                   count;

  int tests_run;
  int tests_failed;

  logic [PC_WIDTH-1:0] exp_q[$];

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .fetch_valid       (fetch_valid),
    .fetch_instruction (fetch_instruction),
    .fetch_pc          (fetch_pc),
    .fetch_ready       (fetch_ready),
    .flush             (flush),
    .dec_valid         (dec_valid),
    .dec_instruction   (dec_instruction),
    .dec_pc            (dec_pc),
    .dec_ready         (dec_ready),
    .count             (count)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instruction word derived from pc so order checks cover both fields.
  function automatic logic [INSTRUCTION_WIDTH-1:0] instr_of(input logic [PC_WIDTH-1:0] pc);
    return 32'hA500_0000 ^ (pc << 4) ^ pc;
  endfunction

  task automatic idle_inputs();
    fetch_valid       = 1'b0;
    fetch_instruction = '0;
    fetch_pc          = '0;
    flush             = 1'b0;
    dec_ready         = 1'b0;
  endtask

  task automatic push_one(input logic [PC_WIDTH-1:0] pc);
    fetch_valid       = 1'b1;
    fetch_pc          = pc;
    fetch_instruction = instr_of(pc);
    tick();
    fetch_valid       = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    tests_run++;
    if (count !== 3'd0) begin
      tests_failed++; $display("FAIL reset_count: got %0d expected 0", count);
    end
    tests_run++;
    if (dec_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_dec_valid: got %b expected 0", dec_valid);
    end
    tests_run++;
    if (dec_instruction !== NOP_INSTRUCTION) begin
      tests_failed++; $display("FAIL reset_dec_instruction: got %h expected %h", dec_instruction, NOP_INSTRUCTION);
    end
    tests_run++;
    if (dec_pc !== '0) begin
      tests_failed++; $display("FAIL reset_dec_pc: got %h expected 0", dec_pc);
    end
    tests_run++;
    if (fetch_ready !== 1'b1) begin
      tests_failed++; $display("FAIL reset_fetch_ready: got %b expected 1", fetch_ready);
    end
  endtask

  task automatic test_single_push();
    rst_n = 1'b1;
    tick();
    fetch_valid       = 1'b1;
    fetch_instruction = 32'h2001_0005;
    fetch_pc          = 32'h10;
    #1;
    tests_run++;
    if (dec_valid !== 1'b0 || dec_instruction !== NOP_INSTRUCTION) begin
      tests_failed++;
      $display("FAIL single_no_bypass: got valid=%b instr=%h expected valid=0 instr=%h",
               dec_valid, dec_instruction, NOP_INSTRUCTION);
    end
    tick();
    fetch_valid = 1'b0;
    tests_run++;
    if (dec_valid !== 1'b1 || dec_instruction !== 32'h2001_0005 || dec_pc !== 32'h10) begin
      tests_failed++;
      $display("FAIL single_head: got valid=%b instr=%h pc=%h expected 1 20010005 00000010",
               dec_valid, dec_instruction, dec_pc);
    end
    tests_run++;
    if (count !== 3'd1) begin
      tests_failed++; $display("FAIL single_count: got %0d expected 1", count);
    end
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    tests_run++;
    if (count !== 3'd0 || dec_valid !== 1'b0) begin
      tests_failed++; $display("FAIL single_pop: got count=%0d valid=%b expected 0 0", count, dec_valid);
    end
  endtask

  task automatic test_fill_to_full();
    dec_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_one(PC_WIDTH'(i));
    tests_run++;
    if (count !== 3'd4 || fetch_ready !== 1'b0) begin
      tests_failed++; $display("FAIL full_state: got count=%0d ready=%b expected 4 0", count, fetch_ready);
    end
    push_one(32'h4);
    tests_run++;
    if (count !== 3'd4) begin
      tests_failed++; $display("FAIL full_drop: got count=%0d expected 4", count);
    end
    dec_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      tests_run++;
      if (dec_valid !== 1'b1 || dec_pc !== PC_WIDTH'(i) || dec_instruction !== instr_of(PC_WIDTH'(i))) begin
        tests_failed++;
        $display("FAIL full_drain_%0d: got valid=%b pc=%h instr=%h expected pc=%h instr=%h",
                 i, dec_valid, dec_pc, dec_instruction, i, instr_of(PC_WIDTH'(i)));
      end
      tick();
    end
    dec_ready = 1'b0;
    tests_run++;
    if (count !== 3'd0 || dec_valid !== 1'b0) begin
      tests_failed++; $display("FAIL full_empty: got count=%0d valid=%b expected 0 0", count, dec_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [PC_WIDTH-1:0] exp_pc;
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      push_one(32'h100 + PC_WIDTH'(i));
      exp_q.push_back(32'h100 + PC_WIDTH'(i));
    end
    for (int i = 2; i < 8; i++) begin
      fetch_valid       = 1'b1;
      fetch_pc          = 32'h100 + PC_WIDTH'(i);
      fetch_instruction = instr_of(fetch_pc);
      dec_ready         = 1'b1;
      exp_pc = exp_q.pop_front();
      exp_q.push_back(fetch_pc);
      tests_run++;
      if (dec_pc !== exp_pc || dec_instruction !== instr_of(exp_pc) || count !== 3'd2) begin
        tests_failed++;
        $display("FAIL b2b_%0d: got pc=%h instr=%h count=%0d expected pc=%h count=2",
                 i, dec_pc, dec_instruction, count, exp_pc);
      end
      tick();
    end
    fetch_valid = 1'b0;
    while (exp_q.size() > 0) begin
      exp_pc = exp_q.pop_front();
      tests_run++;
      if (dec_valid !== 1'b1 || dec_pc !== exp_pc) begin
        tests_failed++; $display("FAIL b2b_drain: got valid=%b pc=%h expected pc=%h", dec_valid, dec_pc, exp_pc);
      end
      tick();
    end
    dec_ready = 1'b0;
    tests_run++;
    if (count !== 3'd0) begin
      tests_failed++; $display("FAIL b2b_empty: got count=%0d expected 0", count);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) push_one(32'h200 + PC_WIDTH'(i));
    tests_run++;
    if (count !== 3'd3) begin
      tests_failed++; $display("FAIL flush_pre_count: got %0d expected 3", count);
    end
    fetch_valid       = 1'b1;
    fetch_pc          = 32'h3FF;
    fetch_instruction = instr_of(32'h3FF);
    dec_ready         = 1'b1;
    flush             = 1'b1;
    tick();
    idle_inputs();
    tests_run++;
    if (count !== 3'd0 || dec_valid !== 1'b0 || dec_instruction !== NOP_INSTRUCTION || fetch_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_state: got count=%0d valid=%b instr=%h ready=%b expected 0 0 %h 1",
               count, dec_valid, dec_instruction, fetch_ready, NOP_INSTRUCTION);
    end
    tick();
    tests_run++;
    if (count !== 3'd0) begin
      tests_failed++; $display("FAIL flush_push_absent: got count=%0d expected 0", count);
    end
    push_one(32'h400);
    tests_run++;
    if (count !== 3'd1 || dec_pc !== 32'h400) begin
      tests_failed++; $display("FAIL flush_resume: got count=%0d pc=%h expected 1 00000400", count, dec_pc);
    end
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
  endtask

  task automatic test_stall();
    push_one(32'h500);
    dec_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (dec_valid !== 1'b1 || dec_pc !== 32'h500 || dec_instruction !== instr_of(32'h500) || count !== 3'd1) begin
        tests_failed++;
        $display("FAIL stall_%0d: got valid=%b pc=%h instr=%h count=%0d expected 1 00000500 %h 1",
                 i, dec_valid, dec_pc, dec_instruction, count, instr_of(32'h500));
      end
      tick();
    end
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    tests_run++;
    if (count !== 3'd0) begin
      tests_failed++; $display("FAIL stall_release: got count=%0d expected 0", count);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) push_one(32'h600 + PC_WIDTH'(i));
    tests_run++;
    if (count !== 3'd3) begin
      tests_failed++; $display("FAIL areset_pre_count: got %0d expected 3", count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (count !== 3'd0 || dec_valid !== 1'b0 || fetch_ready !== 1'b1 || dec_pc !== '0) begin
      tests_failed++;
      $display("FAIL areset_immediate: got count=%0d valid=%b ready=%b pc=%h expected 0 0 1 0",
               count, dec_valid, fetch_ready, dec_pc);
    end
    tick();
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (count !== 3'd0 || dec_valid !== 1'b0) begin
      tests_failed++; $display("FAIL areset_held_empty: got count=%0d valid=%b expected 0 0", count, dec_valid);
    end
    push_one(32'h700);
    tests_run++;
    if (count !== 3'd1 || dec_pc !== 32'h700 || dec_instruction !== instr_of(32'h700)) begin
      tests_failed++;
      $display("FAIL areset_resume: got count=%0d pc=%h instr=%h expected 1 00000700 %h",
               count, dec_pc, dec_instruction, instr_of(32'h700));
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    idle_inputs();
    test_reset();
    test_single_push();
    test_fill_to_full();
    test_back_to_back();
    test_flush();
    test_stall();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_if_id_queue
